// File: rtl/controlador_execucao.sv
// Host-side Run/Done sequencer: single-step, run-N and free-run execution with stop requests.
// Optional Done watchdog and ERROR state are built only when WATCHDOG_EN is defined.
module controlador_execucao #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Clear,
    input  logic [1:0]       Mode,
    input  logic [CNT_W-1:0] Count_N,
    input  logic             Done,
    output logic             Run,
    output logic             Busy,
    output logic             Halted,
    output logic             Timeout_err,
    output logic [CNT_W-1:0] Instr_count,
    output logic [CNT_W-1:0] Cycle_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUNNING = 2'd1;
    localparam logic [1:0] S_HALT    = 2'd2;
    localparam logic [1:0] S_ERROR   = 2'd3;

    localparam logic [1:0] M_STEP  = 2'b00;
    localparam logic [1:0] M_RUN_N = 2'b01;
    localparam logic [1:0] M_FREE  = 2'b10;

    // The watchdog is 8 bits wide; TIMEOUT outside 1..255 leaves this marker block elaborated.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_out_of_range
    end

    logic [1:0]       state, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] remaining, remaining_d;
    logic             stop_pending, stop_pending_d;
    logic [CNT_W-1:0] instr_d, cycle_d;
    logic             halt_now;

`ifdef WATCHDOG_EN
    logic [7:0] watchdog, watchdog_d, watchdog_inc;
    assign watchdog_inc = watchdog + 8'd1;
`endif

    assign halt_now = (mode_q == M_STEP)
                   || (mode_q == M_RUN_N && remaining == CNT_W'(1))
                   || stop_pending || Stop;

    always_comb begin
        state_d        = state;
        mode_d         = mode_q;
        remaining_d    = remaining;
        stop_pending_d = stop_pending;
        instr_d        = Instr_count;
        cycle_d        = Cycle_count;
`ifdef WATCHDOG_EN
        watchdog_d     = watchdog;
`endif
        case (state)
            S_IDLE, S_HALT: begin
                if (Clear && state == S_HALT) begin
                    state_d = S_IDLE;
                end else if (Start && !Stop) begin
                    mode_d         = (Mode == M_RUN_N || Mode == M_FREE) ? Mode : M_STEP;
                    remaining_d    = (Mode == M_RUN_N) ? Count_N : CNT_W'(1);
                    stop_pending_d = 1'b0;
`ifdef WATCHDOG_EN
                    watchdog_d     = '0;
`endif
                    state_d = (Mode == M_RUN_N && Count_N == '0) ? S_HALT : S_RUNNING;
                end
            end
            S_RUNNING: begin
                if (Cycle_count != '1) cycle_d = Cycle_count + CNT_W'(1);
                if (Done) begin
                    if (Instr_count != '1) instr_d = Instr_count + CNT_W'(1);
                    if (remaining != '0) remaining_d = remaining - CNT_W'(1);
`ifdef WATCHDOG_EN
                    watchdog_d = '0;
`endif
                    if (halt_now) begin
                        state_d        = S_HALT;
                        stop_pending_d = 1'b0;
                    end
                end else begin
                    if (Stop) stop_pending_d = 1'b1;
`ifdef WATCHDOG_EN
                    if (watchdog_inc == 8'(TIMEOUT)) state_d = S_ERROR;
                    else                             watchdog_d = watchdog_inc;
`endif
                end
            end
            S_ERROR: begin
                if (Clear) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Clear in RUNNING zeroes the counters but leaves the in-flight sequence alone.
        if (Clear) begin
            instr_d        = '0;
            cycle_d        = '0;
            stop_pending_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state        <= S_IDLE;
            mode_q       <= M_STEP;
            remaining    <= '0;
            stop_pending <= 1'b0;
            Instr_count  <= '0;
            Cycle_count  <= '0;
            Run          <= 1'b0;
            Busy         <= 1'b0;
            Halted       <= 1'b0;
        end else begin
            state        <= state_d;
            mode_q       <= mode_d;
            remaining    <= remaining_d;
            stop_pending <= stop_pending_d;
            Instr_count  <= instr_d;
            Cycle_count  <= cycle_d;
            Run          <= (state_d == S_RUNNING);
            Busy         <= (state_d == S_RUNNING);
            Halted       <= (state_d == S_HALT);
        end
    end

`ifdef WATCHDOG_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            watchdog    <= '0;
            Timeout_err <= 1'b0;
        end else begin
            watchdog    <= watchdog_d;
            Timeout_err <= (state_d == S_ERROR);
        end
    end
`else
    assign Timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_controlador_execucao.sv
// Self-checking bench for controlador_execucao: table of execution scenarios with a
// scoreboard, plus hand-written reset, ignore and watchdog sequences.
module tb_controlador_execucao;

    localparam int CW = 5;

    logic          Clock = 1'b0;
    logic          Resetn, Start, Stop, Clear, Done;
    logic [1:0]    Mode;
    logic [CW-1:0] Count_N;
    logic          Run, Busy, Halted, Timeout_err;
    logic [CW-1:0] Instr_count, Cycle_count;

    int checks = 0;
    int errors = 0;

    controlador_execucao #(.CNT_W(CW), .TIMEOUT(15)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop), .Clear(Clear),
        .Mode(Mode), .Count_N(Count_N), .Done(Done), .Run(Run), .Busy(Busy),
        .Halted(Halted), .Timeout_err(Timeout_err),
        .Instr_count(Instr_count), .Cycle_count(Cycle_count)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic          clr;
        logic [1:0]    mode;
        logic [CW-1:0] count_n;
        int            gap;
        int            stop_after;
        logic [CW-1:0] exp_instr;
        logic [CW-1:0] exp_cycles;
        int            exp_run;
    } vec_t;

    typedef struct {
        logic [CW-1:0] instr;
        logic [CW-1:0] cycles;
        int            run;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_clear();
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
    endtask

    // Processor model: Done pulses once Run has been high for v.gap cycles since issue.
    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        int cnt = 0, run_seen = 0, dones = 0, stop_cd = 0;
        bit halted_seen = 0;
        if (v.clr) pulse_clear();
        Mode = v.mode; Count_N = v.count_n; Start = 1'b1;
        e.instr = v.exp_instr; e.cycles = v.exp_cycles; e.run = v.exp_run;
        sb.push_back(e);
        @(negedge Clock);
        Start = 1'b0; Mode = 2'b00; Count_N = '0;
        for (int b = 0; b < 200; b++) begin
            if (Halted) begin halted_seen = 1; break; end
            Stop = 1'b0; Done = 1'b0;
            if (stop_cd > 0) begin
                stop_cd--;
                if (stop_cd == 0) Stop = 1'b1;
            end
            if (Run) begin
                run_seen++; cnt++;
                if (cnt == v.gap) begin
                    Done = 1'b1; cnt = 0; dones++;
                    if (v.stop_after != 0 && dones == v.stop_after) stop_cd = 2;
                end
            end
            @(negedge Clock);
        end
        Done = 1'b0; Stop = 1'b0;
        check($sformatf("vec%0d_halted", idx), 32'(halted_seen), 32'd1);
        e = sb.pop_front();
        check($sformatf("vec%0d_instr", idx), 32'(Instr_count), 32'(e.instr));
        check($sformatf("vec%0d_cycles", idx), 32'(Cycle_count), 32'(e.cycles));
        check($sformatf("vec%0d_run_len", idx), 32'(run_seen), 32'(e.run));
        check($sformatf("vec%0d_busy", idx), 32'(Busy), 32'd0);
        check($sformatf("vec%0d_terr", idx), 32'(Timeout_err), 32'd0);
    endtask

    initial begin
        //            clr  mode   N     gap stop  instr  cyc   run
        vecs[0]  = '{1'b1, 2'b00, 5'd0,  4, 0, 5'd1,  5'd4,  4};
        vecs[1]  = '{1'b1, 2'b01, 5'd3,  4, 0, 5'd3,  5'd12, 12};
        vecs[2]  = '{1'b0, 2'b01, 5'd3,  4, 0, 5'd6,  5'd24, 12};
        vecs[3]  = '{1'b1, 2'b10, 5'd0,  4, 2, 5'd3,  5'd12, 12};
        vecs[4]  = '{1'b1, 2'b01, 5'd0,  4, 0, 5'd0,  5'd0,  0};
        vecs[5]  = '{1'b1, 2'b11, 5'd0,  2, 0, 5'd1,  5'd2,  2};
        vecs[6]  = '{1'b1, 2'b01, 5'd5,  1, 0, 5'd5,  5'd5,  5};
        vecs[7]  = '{1'b1, 2'b10, 5'd0,  3, 1, 5'd2,  5'd6,  6};
        vecs[8]  = '{1'b1, 2'b10, 5'd0,  2, 1, 5'd2,  5'd4,  4};
        vecs[9]  = '{1'b1, 2'b01, 5'd4,  4, 1, 5'd2,  5'd8,  8};
        vecs[10] = '{1'b1, 2'b01, 5'd31, 1, 0, 5'd31, 5'd31, 31};
        vecs[11] = '{1'b0, 2'b01, 5'd31, 1, 0, 5'd31, 5'd31, 31};

        Resetn = 1'b0; Start = 1'b0; Stop = 1'b0; Clear = 1'b0; Done = 1'b0;
        Mode = 2'b00; Count_N = '0;
        repeat (3) @(negedge Clock);
        check("rst_run", 32'(Run), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_halted", 32'(Halted), 32'd0);
        check("rst_terr", 32'(Timeout_err), 32'd0);
        check("rst_instr", 32'(Instr_count), 32'd0);
        check("rst_cycles", 32'(Cycle_count), 32'd0);
        Resetn = 1'b1;
        @(negedge Clock);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Done outside RUNNING must not touch the counters.
        pulse_clear();
        check("clr_halted", 32'(Halted), 32'd0);
        Done = 1'b1;
        repeat (3) @(negedge Clock);
        Done = 1'b0;
        check("idle_done_instr", 32'(Instr_count), 32'd0);
        check("idle_done_cycles", 32'(Cycle_count), 32'd0);
        check("idle_done_run", 32'(Run), 32'd0);

        // Start together with Stop is ignored.
        Mode = 2'b10; Start = 1'b1; Stop = 1'b1;
        @(negedge Clock);
        Start = 1'b0; Stop = 1'b0;
        check("start_stop_busy", 32'(Busy), 32'd0);
        check("start_stop_run", 32'(Run), 32'd0);

        // Asynchronous reset in the middle of a free-run.
        Mode = 2'b10; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (2) @(negedge Clock);
        check("midrun_run_before", 32'(Run), 32'd1);
        check("midrun_cycles_before", 32'(Cycle_count), 32'd2);
        #2 Resetn = 1'b0;
        #1;
        check("midrun_run", 32'(Run), 32'd0);
        check("midrun_busy", 32'(Busy), 32'd0);
        check("midrun_cycles", 32'(Cycle_count), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        Done = 1'b1;
        repeat (3) @(negedge Clock);
        Done = 1'b0;
        check("post_rst_instr", 32'(Instr_count), 32'd0);
        check("post_rst_run", 32'(Run), 32'd0);
        check("post_rst_halted", 32'(Halted), 32'd0);

`ifdef WATCHDOG_EN
        begin
            int run_seen = 0;
            bit dropped = 0;
            Mode = 2'b00; Start = 1'b1;
            @(negedge Clock);
            Start = 1'b0;
            for (int b = 0; b < 100; b++) begin
                if (!Run) begin dropped = 1; break; end
                run_seen++;
                @(negedge Clock);
            end
            check("wd_dropped", 32'(dropped), 32'd1);
            check("wd_run_len", 32'(run_seen), 32'd15);
            check("wd_terr", 32'(Timeout_err), 32'd1);
            check("wd_cycles", 32'(Cycle_count), 32'd15);
            check("wd_halted", 32'(Halted), 32'd0);
            Start = 1'b1;
            @(negedge Clock);
            Start = 1'b0;
            @(negedge Clock);
            check("wd_start_ignored", 32'(Run), 32'd0);
            check("wd_terr_sticky", 32'(Timeout_err), 32'd1);
            pulse_clear();
            check("wd_clr_terr", 32'(Timeout_err), 32'd0);
            check("wd_clr_cycles", 32'(Cycle_count), 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
